// File: rtl/knap_search_ctrl.sv
// Exhaustive knapsack subset search: sums one subset per clock, then compares it against the latched limits.
// Latency: done pulses 2^N_ITEMS+2 cycles after an accepted start. Stage 1 sums, stage 2 compares.
// Backpressure: none. start and cfg_we are ignored while busy, so the table and limits stay frozen during a scan.
module knap_search_ctrl #(
  parameter int N_ITEMS = 5,
  parameter int W       = 32,
  localparam int IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [W-1:0]       cfg_value,
  input  logic [W-1:0]       cfg_weight,
  input  logic [W-1:0]       cfg_volume,
  input  logic [W-1:0]       min_value,
  input  logic [W-1:0]       max_weight,
  input  logic [W-1:0]       max_volume,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_ITEMS-1:0] best_mask,
  output logic [W-1:0]       best_value,
  output logic [N_ITEMS:0]   valid_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  state_t state, state_nxt;

  logic [W-1:0]       tab_value  [N_ITEMS];
  logic [W-1:0]       tab_weight [N_ITEMS];
  logic [W-1:0]       tab_volume [N_ITEMS];
  logic [W-1:0]       min_l, max_weight_l, max_volume_l;
  logic [N_ITEMS-1:0] mask;
  logic [W-1:0]       sum_value, sum_weight, sum_volume;
  logic [W-1:0]       s1_value, s1_weight, s1_volume;
  logic [N_ITEMS-1:0] s1_mask;
  logic               s1_vld;
  logic               start_acc, scan_last, s2_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    scan_last = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        scan_last = &mask;
        if (scan_last) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Indices with no matching item never hit any entry, so out-of-range writes drop out.
  for (genvar i = 0; i < N_ITEMS; i++) begin : g_tab
    always_ff @(posedge clk) begin
      if (rst) begin
        tab_value[i]  <= '0;
        tab_weight[i] <= '0;
        tab_volume[i] <= '0;
      end else if (cfg_we && !busy && cfg_idx == IDX_W'(i)) begin
        tab_value[i]  <= cfg_value;
        tab_weight[i] <= cfg_weight;
        tab_volume[i] <= cfg_volume;
      end
    end
  end

  always_comb begin
    sum_value  = '0;
    sum_weight = '0;
    sum_volume = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (mask[i]) begin
        sum_value  = sum_value  + tab_value[i];
        sum_weight = sum_weight + tab_weight[i];
        sum_volume = sum_volume + tab_volume[i];
      end
    end
  end

  assign s2_valid = s1_vld && (s1_value >= min_l) &&
                    (s1_weight <= max_weight_l) && (s1_volume <= max_volume_l);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      best_mask    <= '0;
      best_value   <= '0;
      valid_count  <= '0;
      min_l        <= '0;
      max_weight_l <= '0;
      max_volume_l <= '0;
      mask         <= '0;
      s1_value     <= '0;
      s1_weight    <= '0;
      s1_volume    <= '0;
      s1_mask      <= '0;
      s1_vld       <= 1'b0;
    end else begin
      done   <= (state == FIN);
      s1_vld <= (state == SCAN);
      if (state == SCAN) begin
        s1_value  <= sum_value;
        s1_weight <= sum_weight;
        s1_volume <= sum_volume;
        s1_mask   <= mask;
        // Hold on the final mask so the counter never starts a second pass.
        if (!scan_last) mask <= mask + 1'b1;
      end
      if (start_acc) begin
        min_l        <= min_value;
        max_weight_l <= max_weight;
        max_volume_l <= max_volume;
        found        <= 1'b0;
        best_mask    <= '0;
        best_value   <= '0;
        valid_count  <= '0;
        mask         <= '0;
        busy         <= 1'b1;
      end else if (s2_valid) begin
        valid_count <= valid_count + 1'b1;
        // Strictly greater: on equal value the earlier (lower) mask is kept.
        if (!found || s1_value > best_value) begin
          found      <= 1'b1;
          best_mask  <= s1_mask;
          best_value <= s1_value;
        end
      end
      if (state == FIN) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_knap_search_ctrl.sv
// Bench for knap_search_ctrl: spec vectors, multi-cycle corner sequences and random tables
// checked against a subset-enumeration model.
module tb_knap_search_ctrl;
  localparam int N     = 5;
  localparam int W     = 32;
  localparam int IDX_W = 3;
  localparam int LAT   = (1 << N) + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [W-1:0]     cfg_value, cfg_weight, cfg_volume;
  logic [W-1:0]     min_value, max_weight, max_volume;
  logic             start;
  logic             busy, done, found;
  logic [N-1:0]     best_mask;
  logic [W-1:0]     best_value;
  logic [N:0]       valid_count;

  always #5 clk = ~clk;

  knap_search_ctrl #(.N_ITEMS(N), .W(W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_value(cfg_value), .cfg_weight(cfg_weight), .cfg_volume(cfg_volume),
    .min_value(min_value), .max_weight(max_weight), .max_volume(max_volume),
    .start(start), .busy(busy), .done(done), .found(found),
    .best_mask(best_mask), .best_value(best_value), .valid_count(valid_count)
  );

  typedef struct {
    string        name;
    logic [W-1:0] mn, mw, mv;
    logic         ef;
    logic [N-1:0] em;
    logic [W-1:0] ev;
    logic [N:0]   ec;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_val [N];
  logic [W-1:0] m_wt  [N];
  logic [W-1:0] m_vol [N];

  logic [W-1:0] plan_val [N] = '{32'd4, 32'd2, 32'd2, 32'd1, 32'd10};
  logic [W-1:0] plan_wt  [N] = '{32'd12, 32'd1, 32'd2, 32'd1, 32'd4};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic cfg_write(input int idx, input logic [W-1:0] v, input logic [W-1:0] wt,
                           input logic [W-1:0] vo);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx[IDX_W-1:0];
    cfg_value = v; cfg_weight = wt; cfg_volume = vo;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (idx < N) begin
      m_val[idx] = v; m_wt[idx] = wt; m_vol[idx] = vo;
    end
  endtask

  task automatic load_plan();
    for (int i = 0; i < N; i++) cfg_write(i, plan_val[i], plan_wt[i], 32'd1);
  endtask

  // Enumerate every subset and apply the selection rules directly.
  task automatic model(input logic [W-1:0] mn, input logic [W-1:0] mw, input logic [W-1:0] mv,
                       output logic f, output logic [N-1:0] bm, output logic [W-1:0] bv,
                       output logic [N:0] cnt);
    logic [W-1:0] sv, sw, so;
    f = 1'b0; bm = '0; bv = '0; cnt = '0;
    for (int m = 0; m < (1 << N); m++) begin
      sv = '0; sw = '0; so = '0;
      for (int i = 0; i < N; i++) begin
        if (m[i]) begin
          sv = sv + m_val[i]; sw = sw + m_wt[i]; so = so + m_vol[i];
        end
      end
      if (sv >= mn && sw <= mw && so <= mv) begin
        cnt = cnt + 1'b1;
        if (!f || sv > bv) begin
          f = 1'b1; bm = m[N-1:0]; bv = sv;
        end
      end
    end
  endtask

  // Runs one search; optionally pokes start and a cfg write at loop cycle inject_at.
  task automatic run_search(input string tag, input logic [W-1:0] mn, input logic [W-1:0] mw,
                            input logic [W-1:0] mv, input int inject_at);
    int lat;
    @(negedge clk);
    min_value = mn; max_weight = mw; max_volume = mv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      if (c == inject_at) begin
        start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd4;
        cfg_value = 32'd100; cfg_weight = '0; cfg_volume = '0;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    if (lat > 0) begin
      chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      @(negedge clk);
      chk({tag, "_done_single_pulse"}, 64'(done), 64'd0);
    end
  endtask

  task automatic chk_res(input string tag, input logic ef, input logic [N-1:0] em,
                         input logic [W-1:0] ev, input logic [N:0] ec);
    chk({tag, "_found"}, 64'(found), 64'(ef));
    chk({tag, "_best_mask"}, 64'(best_mask), 64'(em));
    chk({tag, "_best_value"}, 64'(best_value), 64'(ev));
    chk({tag, "_valid_count"}, 64'(valid_count), 64'(ec));
  endtask

  task automatic chk_model(input string tag, input logic [W-1:0] mn, input logic [W-1:0] mw,
                           input logic [W-1:0] mv);
    logic         f;
    logic [N-1:0] bm;
    logic [W-1:0] bv;
    logic [N:0]   cnt;
    model(mn, mw, mv, f, bm, bv, cnt);
    chk_res(tag, f, bm, bv, cnt);
  endtask

  initial begin
    vec_t vt[4];
    int   dn;
    logic [W-1:0] rmn, rmw, rmv;

    vt[0] = '{"plan_min15", 32'd15, 32'd16, 32'd5, 1'b1, 5'h1E, 32'd15, 6'd1};
    vt[1] = '{"plan_all",   32'd0, 32'd1000, 32'd5, 1'b1, 5'h1F, 32'd19, 6'd32};
    vt[2] = '{"plan_none",  32'd20, 32'd16, 32'd5, 1'b0, 5'h00, 32'd0, 6'd0};
    vt[3] = '{"plan_vol2",  32'd0, 32'd1000, 32'd2, 1'b1, 5'h11, 32'd14, 6'd16};

    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; start = 1'b0;
    cfg_value = '0; cfg_weight = '0; cfg_volume = '0;
    min_value = '0; max_weight = '0; max_volume = '0;
    for (int i = 0; i < N; i++) begin
      m_val[i] = '0; m_wt[i] = '0; m_vol[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk_res("rst", 1'b0, '0, '0, '0);
    rst = 1'b0;

    // Cleared table: every subset sums to zero and passes zero limits.
    run_search("zero_tab", 32'd0, 32'd0, 32'd0, 0);
    chk_res("zero_tab", 1'b1, 5'h00, 32'd0, 6'd32);

    load_plan();
    cfg_write(5, 32'd999, 32'd0, 32'd0);
    cfg_write(7, 32'd999, 32'd0, 32'd0);
    for (int v = 0; v < 4; v++) begin
      run_search(vt[v].name, vt[v].mn, vt[v].mw, vt[v].mv, 0);
      chk_res(vt[v].name, vt[v].ef, vt[v].em, vt[v].ev, vt[v].ec);
    end

    repeat (5) @(negedge clk);
    chk_res("hold", 1'b1, 5'h11, 32'd14, 6'd16);

    for (int i = 0; i < N; i++) cfg_write(i, (i < 2) ? 32'd5 : 32'd0, 32'd0, 32'd1);
    run_search("tie", 32'd5, 32'd0, 32'd1, 0);
    chk_res("tie", 1'b1, 5'h01, 32'd5, 6'd2);

    // Abort mid-search while results are non-zero.
    load_plan();
    @(negedge clk);
    min_value = 32'd0; max_weight = 32'd1000; max_volume = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk_res("abort", 1'b0, '0, '0, '0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_val[i] = '0; m_wt[i] = '0; m_vol[i] = '0;
    end
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    load_plan();
    run_search("restart", 32'd15, 32'd16, 32'd5, 0);
    chk_res("restart", 1'b1, 5'h1E, 32'd15, 6'd1);

    run_search("inject", 32'd15, 32'd16, 32'd5, 10);
    chk_res("inject", 1'b1, 5'h1E, 32'd15, 6'd1);
    run_search("readback", 32'd0, 32'd1000, 32'd5, 0);
    chk_res("readback", 1'b1, 5'h1F, 32'd19, 6'd32);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        cfg_write(i, (r % 3 == 2) ? $urandom : $urandom_range(0, 20),
                  $urandom_range(0, 15), $urandom_range(0, 3));
      rmn = (r % 3 == 2) ? $urandom : $urandom_range(0, 40);
      rmw = $urandom_range(0, 40);
      rmv = $urandom_range(0, 10);
      run_search($sformatf("rand%0d", r), rmn, rmw, rmv, 0);
      chk_model($sformatf("rand%0d", r), rmn, rmw, rmv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
